// File: rtl/rf_scoreboard.sv
// Register file with two write ports, two combinational read ports and a
// per-register pending (scoreboard) bit. Reserving a register at issue marks
// it pending; writing it back clears the pending bit. The count of pending
// registers is registered. Register 0 is hardwired to zero and is never pending.
module rf_scoreboard #(
    parameter int XLEN      = 32,
    parameter int NREG      = 32,
    parameter int BYPASS_EN = 0,
    localparam int AW       = $clog2(NREG),
    localparam int CW       = $clog2(NREG + 1)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [AW-1:0]   i_rs1_raddr,
    output logic [XLEN-1:0] o_rs1_rdata,
    output logic            o_rs1_busy,
    input  logic [AW-1:0]   i_rs2_raddr,
    output logic [XLEN-1:0] o_rs2_rdata,
    output logic            o_rs2_busy,
    input  logic            i_wp0_wen,
    input  logic [AW-1:0]   i_wp0_waddr,
    input  logic [XLEN-1:0] i_wp0_wdata,
    input  logic            i_wp1_wen,
    input  logic [AW-1:0]   i_wp1_waddr,
    input  logic [XLEN-1:0] i_wp1_wdata,
    input  logic            i_rsv_en,
    input  logic [AW-1:0]   i_rsv_addr,
    output logic [CW-1:0]   o_busy_cnt
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] pend;
    logic [NREG-1:0] pend_nxt;
    logic [CW-1:0]   cnt_nxt;
    logic [CW-1:0]   busy_cnt;

    logic wr0_act;
    logic wr1_act;
    logic rsv_act;

    assign wr0_act = i_wp0_wen && (i_wp0_waddr != '0);
    assign wr1_act = i_wp1_wen && (i_wp1_waddr != '0);
    assign rsv_act = i_rsv_en  && (i_rsv_addr  != '0);

    // Read data: x0 is zero; bypass (when built in) forwards this cycle's
    // write data, port 1 taking precedence over port 0.
    function automatic logic [XLEN-1:0] rd_data(input logic [AW-1:0] addr);
        logic [XLEN-1:0] d;
        d = regs[addr];
        if (BYPASS_EN != 0) begin
            if (wr0_act && (i_wp0_waddr == addr)) d = i_wp0_wdata;
            if (wr1_act && (i_wp1_waddr == addr)) d = i_wp1_wdata;
        end
        if (addr == '0) d = '0;
        return d;
    endfunction

    // Busy: stored pending bit, suppressed when a bypassed write resolves it.
    // A same-cycle reserve deliberately does not show up here.
    function automatic logic rd_busy(input logic [AW-1:0] addr);
        logic b;
        b = pend[addr];
        if (BYPASS_EN != 0) begin
            if (wr0_act && (i_wp0_waddr == addr)) b = 1'b0;
            if (wr1_act && (i_wp1_waddr == addr)) b = 1'b0;
        end
        if (addr == '0) b = 1'b0;
        return b;
    endfunction

    // Combinational read ports
    always_comb begin
        o_rs1_rdata = rd_data(i_rs1_raddr);
        o_rs1_busy  = rd_busy(i_rs1_raddr);
        o_rs2_rdata = rd_data(i_rs2_raddr);
        o_rs2_busy  = rd_busy(i_rs2_raddr);
    end

    // Next pending vector: writes clear, then reserve sets (newer producer wins)
    always_comb begin
        pend_nxt = pend;
        if (wr0_act) pend_nxt[i_wp0_waddr] = 1'b0;
        if (wr1_act) pend_nxt[i_wp1_waddr] = 1'b0;
        if (rsv_act) pend_nxt[i_rsv_addr]  = 1'b1;
        pend_nxt[0] = 1'b0;
    end

    // Population count of the next pending vector, registered alongside it
    always_comb begin
        cnt_nxt = '0;
        for (int i = 1; i < NREG; i++) begin
            cnt_nxt = cnt_nxt + CW'(pend_nxt[i]);
        end
    end

    // Register storage; port 1 overrides port 0 on an address collision
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wr0_act && !(wr1_act && (i_wp1_waddr == i_wp0_waddr))) begin
                regs[i_wp0_waddr] <= i_wp0_wdata;
            end
            if (wr1_act) begin
                regs[i_wp1_waddr] <= i_wp1_wdata;
            end
        end
    end

    // Pending bits and their count
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pend     <= '0;
            busy_cnt <= '0;
        end else begin
            pend     <= pend_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

    assign o_busy_cnt = busy_cnt;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Bench for rf_scoreboard: one instance without bypass and one with bypass,
// sharing stimulus. Each issued cycle pushes expected read/busy/count values
// from a plain array model; a monitor pops and compares on the falling edge.
module tb_rf_scoreboard;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int CW   = 6;

    logic            clk;
    logic            rst;
    logic [AW-1:0]   rs1_raddr, rs2_raddr;
    logic            wp0_wen, wp1_wen, rsv_en;
    logic [AW-1:0]   wp0_waddr, wp1_waddr, rsv_addr;
    logic [XLEN-1:0] wp0_wdata, wp1_wdata;

    logic [XLEN-1:0] rd1_n, rd2_n, rd1_b, rd2_b;
    logic            bz1_n, bz2_n, bz1_b, bz2_b;
    logic [CW-1:0]   cnt_n, cnt_b;

    rf_scoreboard #(.XLEN(XLEN), .NREG(NREG), .BYPASS_EN(0)) u_nobyp (
        .i_clk(clk), .i_rst(rst),
        .i_rs1_raddr(rs1_raddr), .o_rs1_rdata(rd1_n), .o_rs1_busy(bz1_n),
        .i_rs2_raddr(rs2_raddr), .o_rs2_rdata(rd2_n), .o_rs2_busy(bz2_n),
        .i_wp0_wen(wp0_wen), .i_wp0_waddr(wp0_waddr), .i_wp0_wdata(wp0_wdata),
        .i_wp1_wen(wp1_wen), .i_wp1_waddr(wp1_waddr), .i_wp1_wdata(wp1_wdata),
        .i_rsv_en(rsv_en), .i_rsv_addr(rsv_addr), .o_busy_cnt(cnt_n)
    );

    rf_scoreboard #(.XLEN(XLEN), .NREG(NREG), .BYPASS_EN(1)) u_byp (
        .i_clk(clk), .i_rst(rst),
        .i_rs1_raddr(rs1_raddr), .o_rs1_rdata(rd1_b), .o_rs1_busy(bz1_b),
        .i_rs2_raddr(rs2_raddr), .o_rs2_rdata(rd2_b), .o_rs2_busy(bz2_b),
        .i_wp0_wen(wp0_wen), .i_wp0_waddr(wp0_waddr), .i_wp0_wdata(wp0_wdata),
        .i_wp1_wen(wp1_wen), .i_wp1_waddr(wp1_waddr), .i_wp1_wdata(wp1_wdata),
        .i_rsv_en(rsv_en), .i_rsv_addr(rsv_addr), .o_busy_cnt(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] d1_n, d2_n, d1_b, d2_b;
        logic            b1_n, b2_n, b1_b, b2_b;
        logic [CW-1:0]   cnt;
    } exp_t;

    exp_t q[$];

    // Reference model state
    logic [XLEN-1:0] mregs [NREG];
    bit              mpend [NREG];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] m_read(input bit byp, input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (byp && wp1_wen && wp1_waddr == a) return wp1_wdata;
        if (byp && wp0_wen && wp0_waddr == a) return wp0_wdata;
        return mregs[a];
    endfunction

    function automatic logic m_busy(input bit byp, input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
        if (byp && ((wp1_wen && wp1_waddr == a) || (wp0_wen && wp0_waddr == a))) return 1'b0;
        return mpend[a];
    endfunction

    function automatic logic [CW-1:0] m_count();
        int c = 0;
        for (int i = 0; i < NREG; i++) c += int'(mpend[i]);
        return CW'(c);
    endfunction

    // Apply inputs for this cycle, queue the expected response, advance model
    task automatic drive(input bit r, input int ra1, input int ra2,
                         input bit w0e, input int w0a, input logic [XLEN-1:0] w0d,
                         input bit w1e, input int w1a, input logic [XLEN-1:0] w1d,
                         input bit re, input int rsa);
        exp_t e;
        rst       = r;
        rs1_raddr = AW'(ra1);
        rs2_raddr = AW'(ra2);
        wp0_wen   = w0e; wp0_waddr = AW'(w0a); wp0_wdata = w0d;
        wp1_wen   = w1e; wp1_waddr = AW'(w1a); wp1_wdata = w1d;
        rsv_en    = re;  rsv_addr  = AW'(rsa);
        e.d1_n = m_read(0, rs1_raddr); e.b1_n = m_busy(0, rs1_raddr);
        e.d2_n = m_read(0, rs2_raddr); e.b2_n = m_busy(0, rs2_raddr);
        e.d1_b = m_read(1, rs1_raddr); e.b1_b = m_busy(1, rs1_raddr);
        e.d2_b = m_read(1, rs2_raddr); e.b2_b = m_busy(1, rs2_raddr);
        e.cnt  = m_count();
        q.push_back(e);
        if (r) begin
            for (int i = 0; i < NREG; i++) begin
                mregs[i] = '0;
                mpend[i] = 1'b0;
            end
        end else begin
            if (w0e && w0a != 0) begin mregs[w0a] = w0d; mpend[w0a] = 1'b0; end
            if (w1e && w1a != 0) begin mregs[w1a] = w1d; mpend[w1a] = 1'b0; end
            if (re && rsa != 0) mpend[rsa] = 1'b1;
        end
    endtask

    task automatic rd(input int ra1, input int ra2);
        drive(0, ra1, ra2, 0, 0, '0, 0, 0, '0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every issued cycle's outputs on the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sb_rs1_data_nobyp", rd1_n, e.d1_n);
                chk("sb_rs1_busy_nobyp", 32'(bz1_n), 32'(e.b1_n));
                chk("sb_rs2_data_nobyp", rd2_n, e.d2_n);
                chk("sb_rs2_busy_nobyp", 32'(bz2_n), 32'(e.b2_n));
                chk("sb_cnt_nobyp", 32'(cnt_n), 32'(e.cnt));
                chk("sb_rs1_data_byp", rd1_b, e.d1_b);
                chk("sb_rs1_busy_byp", 32'(bz1_b), 32'(e.b1_b));
                chk("sb_rs2_data_byp", rd2_b, e.d2_b);
                chk("sb_rs2_busy_byp", 32'(bz2_b), 32'(e.b2_b));
                chk("sb_cnt_byp", 32'(cnt_b), 32'(e.cnt));
            end
        end
    end

    initial begin
        for (int i = 0; i < NREG; i++) begin
            mregs[i] = '0;
            mpend[i] = 1'b0;
        end
        rst = 1'b1;
        rs1_raddr = '0; rs2_raddr = '0;
        wp0_wen = 0; wp0_waddr = '0; wp0_wdata = '0;
        wp1_wen = 0; wp1_waddr = '0; wp1_wdata = '0;
        rsv_en = 0; rsv_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        drive(1, 0, 0, 0, 0, '0, 0, 0, '0, 0, 0);
        tick();

        // Reset state
        rd(5, 9);
        #2;
        chk("reset_cnt", 32'(cnt_n), 0);
        chk("reset_rs1_data", rd1_n, 0);
        chk("reset_rs2_busy", 32'(bz2_n), 0);
        tick();

        // Basic write then read; x0 reads zero
        drive(0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, '0, 0, 0);
        tick();
        rd(5, 0);
        #2;
        chk("basic_x5", rd1_n, 32'hDEADBEEF);
        chk("basic_x0", rd2_n, 0);
        tick();

        // Same-address write collision: port 1 wins
        drive(0, 0, 0, 1, 7, 32'h11, 1, 7, 32'h22, 0, 0);
        tick();
        rd(7, 0);
        #2;
        chk("collide_x7", rd1_n, 32'h22);
        tick();

        // Reserve x3, then write it back
        drive(0, 0, 0, 0, 0, '0, 0, 0, '0, 1, 3);
        tick();
        drive(0, 3, 0, 1, 3, 32'h33, 0, 0, '0, 0, 0);
        #2;
        chk("rsv_x3_busy", 32'(bz1_n), 1);
        chk("rsv_x3_cnt", 32'(cnt_n), 1);
        tick();
        rd(3, 0);
        #2;
        chk("wb_x3_busy", 32'(bz1_n), 0);
        chk("wb_x3_cnt", 32'(cnt_n), 0);
        tick();

        // Reserve and write hit x4 together: data updates, stays pending
        drive(0, 0, 0, 0, 0, '0, 0, 0, '0, 1, 4);
        tick();
        drive(0, 4, 0, 0, 0, '0, 1, 4, 32'h44, 1, 4);
        #2;
        chk("rsv_wr_pre_cnt", 32'(cnt_n), 1);
        tick();
        rd(4, 0);
        #2;
        chk("rsv_wr_x4_data", rd1_n, 32'h44);
        chk("rsv_wr_x4_busy", 32'(bz1_n), 1);
        chk("rsv_wr_x4_cnt", 32'(cnt_n), 1);
        tick();

        // Bypass of a write to a pending register
        drive(0, 0, 0, 0, 0, '0, 0, 0, '0, 1, 9);
        tick();
        drive(0, 9, 0, 1, 9, 32'hCAFE, 0, 0, '0, 0, 0);
        #2;
        chk("byp_x9_data", rd1_b, 32'hCAFE);
        chk("byp_x9_busy", 32'(bz1_b), 0);
        chk("nobyp_x9_data", rd1_n, 0);
        chk("nobyp_x9_busy", 32'(bz1_n), 1);
        tick();

        // Reset in the middle of activity overrides a write
        drive(0, 0, 0, 1, 2, 32'h5, 0, 0, '0, 1, 6);
        tick();
        drive(1, 2, 6, 1, 2, 32'h77, 0, 0, '0, 1, 10);
        tick();
        rd(2, 6);
        #2;
        chk("midrst_x2", rd1_n, 0);
        chk("midrst_x6_busy", 32'(bz2_n), 0);
        chk("midrst_cnt", 32'(cnt_n), 0);
        chk("midrst_cnt_byp", 32'(cnt_b), 0);
        tick();

        // Randomized traffic, addresses biased toward a small set to force collisions
        for (int n = 0; n < 600; n++) begin
            int a[5];
            for (int k = 0; k < 5; k++) begin
                a[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NREG - 1))
                                                   : int'($urandom_range(0, 5));
            end
            drive(($urandom_range(0, 63) == 0), a[0], a[1],
                  ($urandom_range(0, 1) == 1), a[2], $urandom,
                  ($urandom_range(0, 1) == 1), a[3], $urandom,
                  ($urandom_range(0, 9) < 4), a[4]);
            tick();
        end

        rd(0, 0);
        tick();
        repeat (2) @(posedge clk);
        chk("queue_drained", 32'(q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
